// File: rtl/pck_isa_c.sv
// Shared RV32C encoding helpers and realigner state type used on the fetch side.
package pck_isa_c;

  localparam logic [1:0]  OPCODE_NC = 2'b11;
  localparam logic [15:0] C_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    SKIP  = 2'd2
  } realign_state_e;

  function automatic logic is_compressed(input logic [1:0] op);
    return (op != OPCODE_NC);
  endfunction

endpackage

// File: rtl/realign_out_reg.sv
// Single-entry valid/ready register that holds one decoded-side instruction slot.
module realign_out_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        compressed_i,
  input  logic        illegal_i,
  input  logic        ready_i,
  output logic        free_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        compressed_o,
  output logic        illegal_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        compressed_q;
  logic        illegal_q;

  assign free_o = !valid_q || ready_i;

  // Payload only changes on a load, so a stalled slot stays bit-stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      instr_q      <= 32'h0000_0000;
      pc_q         <= RESET_PC;
      compressed_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (free_o) begin
      valid_q <= load_i;
      if (load_i) begin
        instr_q      <= instr_i;
        pc_q         <= pc_i;
        compressed_q <= compressed_i;
        illegal_q    <= illegal_i;
      end
    end
  end

  assign valid_o      = valid_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign compressed_o = compressed_q;
  assign illegal_o    = illegal_q;

endmodule

// File: rtl/instr_realigner.sv
// Splits aligned fetch words into RV32 instructions with PCs; the compressed
// realignment path (HALF/SKIP states) is built only when ISA_C_EN is defined.
module instr_realigner
  import pck_isa_c::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        i_word_valid,
  input  logic [31:0] i_word,
  output logic        o_word_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_compressed,
  output logic        o_instr_illegal
);

  logic [31:0] pc_q, pc_d;
  logic        ready_s, load_s, slot_free_s, comp_s, ill_s;
  logic [31:0] instr_s;
  logic        unused_s;

`ifdef ISA_C_EN
  localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:1], 1'b0};

  realign_state_e state_q, state_d;
  logic [15:0]    hold_q, hold_d;
  logic           hold_c_s, word_c_s;

  assign unused_s = i_redirect_pc[0];
  assign hold_c_s = is_compressed(hold_q[1:0]);
  assign word_c_s = is_compressed(i_word[1:0]);

  // Next-state, PC advance and output-slot load for the realignment FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    ready_s = 1'b0;
    load_s  = 1'b0;
    instr_s = 32'h0000_0000;
    comp_s  = 1'b0;
    ill_s   = 1'b0;
    if (p_reset) begin
      ready_s = 1'b0;
    end else if (i_redirect) begin
      pc_d    = {i_redirect_pc[31:1], 1'b0};
      state_d = i_redirect_pc[1] ? SKIP : EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          ready_s = slot_free_s;
          load_s  = i_word_valid && slot_free_s;
          if (word_c_s) begin
            instr_s = {16'h0000, i_word[15:0]};
            comp_s  = 1'b1;
            ill_s   = (i_word[15:0] == C_ZERO);
          end else begin
            instr_s = i_word;
          end
          if (load_s && word_c_s) begin
            pc_d    = pc_q + 32'd2;
            hold_d  = i_word[31:16];
            state_d = HALF;
          end else if (load_s) begin
            pc_d = pc_q + 32'd4;
          end else begin
            pc_d = pc_q;
          end
        end
        HALF: begin
          if (hold_c_s) begin
            // Held compressed instruction drains without touching the word port.
            ready_s = 1'b0;
            load_s  = slot_free_s;
            instr_s = {16'h0000, hold_q};
            comp_s  = 1'b1;
            ill_s   = (hold_q == C_ZERO);
            if (load_s) begin
              pc_d    = pc_q + 32'd2;
              state_d = EMPTY;
            end else begin
              state_d = HALF;
            end
          end else begin
            ready_s = slot_free_s;
            load_s  = i_word_valid && slot_free_s;
            instr_s = {i_word[15:0], hold_q};
            if (load_s) begin
              pc_d   = pc_q + 32'd4;
              hold_d = i_word[31:16];
            end else begin
              hold_d = hold_q;
            end
          end
        end
        SKIP: begin
          ready_s = 1'b1;
          if (i_word_valid) begin
            hold_d  = i_word[31:16];
            state_d = HALF;
          end else begin
            state_d = SKIP;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM, PC and held-halfword registers.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q <= BOOT_PC[1] ? SKIP : EMPTY;
      pc_q    <= BOOT_PC;
      hold_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end
`else
  localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

  assign unused_s = ^i_redirect_pc[1:0];

  // Word-per-instruction pass-through with PC tracking.
  always_comb begin
    pc_d    = pc_q;
    ready_s = 1'b0;
    load_s  = 1'b0;
    instr_s = i_word;
    comp_s  = 1'b0;
    ill_s   = 1'b0;
    if (p_reset) begin
      ready_s = 1'b0;
    end else if (i_redirect) begin
      pc_d = {i_redirect_pc[31:2], 2'b00};
    end else begin
      ready_s = slot_free_s;
      load_s  = i_word_valid && slot_free_s;
      if (load_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // PC register.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      pc_q <= BOOT_PC;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

  assign o_word_ready = ready_s;

  realign_out_reg #(
    .RESET_PC (BOOT_PC)
  ) u_out_reg (
    .clk_i        (p_clk),
    .rst_i        (p_reset),
    .flush_i      (i_redirect),
    .load_i       (load_s),
    .instr_i      (instr_s),
    .pc_i         (pc_q),
    .compressed_i (comp_s),
    .illegal_i    (ill_s),
    .ready_i      (i_instr_ready),
    .free_o       (slot_free_s),
    .valid_o      (o_instr_valid),
    .instr_o      (o_instr),
    .pc_o         (o_instr_pc),
    .compressed_o (o_instr_compressed),
    .illegal_o    (o_instr_illegal)
  );

endmodule

// File: doc/instr_realigner.md
# instr_realigner

Fetch-side sequencer that turns the in-order stream of 32-bit aligned instruction-memory words into a stream of individual RV32 instructions, mixing 16-bit compressed and 32-bit encodings. It sits between the fetch unit and the decoder/decompressor. It holds one leftover halfword across fetch words, so 32-bit instructions that straddle a word boundary are reassembled, and it tracks the PC of every emitted instruction. The output is registered and uses a valid/ready handshake toward decode.

## Interface
- BOOT_ADDR, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.
- p_clk  in  1  clock; all state updates on the rising edge.
- p_reset  in  1  **synchronous, active-high reset**.
- i_word_valid  in  1  fetch word available.
- i_word  in  32  fetch word; bits [15:0] are the lower-address halfword.
- o_word_ready  out  1  word accepted when i_word_valid && o_word_ready.
- i_redirect  in  1  single-cycle flush and PC load (branch, jump or trap).
- i_redirect_pc  in  32  new PC; bit 0 ignored.
- o_instr_valid  out  1  instruction present on o_instr.
- i_instr_ready  in  1  decode consumes the instruction when o_instr_valid && i_instr_ready.
- o_instr  out  32  32-bit encoding, or {16'h0, halfword} for a compressed instruction.
- o_instr_pc  out  32  PC of o_instr.
- o_instr_compressed  out  1  o_instr is a 16-bit encoding.
- o_instr_illegal  out  1  compressed halfword equals C_ZERO (16'h0000).

## Operation
- A halfword is compressed when bits [1:0] != OPCODE_NC (2'b11).
- State machine:
  - **EMPTY**: no halfword is held.
  - **HALF**: `hold[15:0]` holds the next unconsumed halfword.
  - **SKIP**: the next accepted word's low half is discarded.
- **EMPTY + word**:
  - Low half compressed: emit it with PC=pc, set pc+=2, hold the upper half, go to HALF.
  - Otherwise: emit the full word, set pc+=4, stay in EMPTY.
- **HALF, hold compressed**: emit hold without consuming a word, set pc+=2, go to EMPTY. o_word_ready is 0 in this case.
- **HALF, hold 32-bit + word**: emit {word[15:0], hold}, set pc+=4, hold word[31:16], stay in HALF.
- **SKIP + word**: treat word[31:16] as the held halfword and go to HALF. Nothing is emitted this cycle.
- **Redirect**: pc <= i_redirect_pc; state <= SKIP if i_redirect_pc[1], else EMPTY. The output register and hold are invalidated.
  - Any word or instruction handshake in the redirect cycle is ignored.
  - Upstream restarts at {i_redirect_pc[31:2], 2'b00} from the next cycle on.
- **Reset**: pc = BOOT_ADDR; state = SKIP if BOOT_ADDR[1], else EMPTY.
- PC arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFE to 0 is legal.

## Timing
- Reset values:
  - o_instr_valid = 0, o_instr = 0, o_instr_pc = BOOT_ADDR.
  - o_instr_compressed = 0, o_instr_illegal = 0.
  - o_word_ready = 0 while p_reset is high.
- Latency: an instruction appears on the outputs one cycle after the word acceptance (or hold emission) that produces it.
- Output register loads when it is empty or consumed in the same cycle. Sustained throughput is one instruction per cycle.
- o_word_ready is 1 when all of the following hold:
  - not in reset and not in a redirect cycle;
  - not (HALF with hold compressed);
  - the output slot is free or being consumed, except in SKIP, where ready ignores the output slot.
- While o_instr_valid && !i_instr_ready, all outputs hold stable.
- Redirect takes priority over every other event in the same cycle. o_instr_valid is 0 in the following cycle.

## Configuration
- `ISA_C_EN` defined: full realignment as above.
- `ISA_C_EN` undefined:
  - Every word is emitted as-is with pc+=4, and the HALF and SKIP states are absent.
  - o_instr_compressed = 0 and o_instr_illegal = 0 always.
  - A redirect or BOOT_ADDR with bit 1 set is truncated to word alignment.

## Structure
- In shared package pck_isa_c:
  - `realign_state_e` (EMPTY, HALF, SKIP);
  - function `is_compressed(logic [1:0])`, which compares against OPCODE_NC;
  - the existing C_ZERO, used for the illegal flag.
- One sub-module: `realign_out_reg`, a single-entry valid/ready output register carrying instr, pc, compressed and illegal.

## Test plan
- Reset with BOOT_ADDR=0; word 32'h0001_0001 (two C.NOPs) → two instructions 32'h0000_0001 at PC 0 and 2, compressed=1, on consecutive cycles. o_word_ready=0 during the second emission.
- Words 32'h0000_0013 then 32'h0000_0093 (two addi) → two 32-bit instructions at PC 0 and 4, compressed=0.
- Straddle: word 32'h0013_0001 then 32'h0001_0000 → C.NOP at PC 0, then 32'h0000_0013 at PC 2. After that, hold is 16'h0001, emitted at PC 6.
- Redirect to 32'h0000_0102, then word 32'h0001_FFFF → low half dropped, C.NOP emitted at PC 0x102.
- Backpressure: i_instr_ready=0 for 5 cycles with a pending word → outputs stable and no word accepted; on release the stream resumes with no loss or duplication.
- Word 32'h0000_0000 → compressed instruction with illegal=1 at PC 0. Redirect in the same cycle as a pending valid → that instruction is dropped and o_instr_valid=0 the next cycle.
